// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci result path: default width, BCD blank code,
// converter state encoding and the decimal digit-count helper.
package fib_pkg;

    localparam int FIB_W = 32;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ceil(w * log10(2)) using fixed-point log10(2) ~= 0.30103
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // add-3 correction; never overflows for legal digits 0..9
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/fib_bcd_conv.sv
// Iterative binary-to-BCD converter (one bit per clock) with valid/ready on both sides.
// Define FIB_BCD_LZB_EN to blank leading zero digits with the 4'hF code.
module fib_bcd_conv
    import fib_pkg::*;
#(
    parameter int W      = FIB_W,
    parameter int DIGITS = bcd_digits(FIB_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndigits
);

    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(DIGITS + 1);

    if (DIGITS < bcd_digits(W)) begin : g_digits_chk
        $error("fib_bcd_conv: DIGITS too small for W");
    end

    state_t              state_r;
    state_t              state_s;
    logic [W-1:0]        bin_r;
    logic [4*DIGITS-1:0] bcd_r;
    logic [CW-1:0]       cnt_r;
    logic [4*DIGITS-1:0] adj_s;
    logic [4*DIGITS-1:0] shifted_s;
    logic [4*DIGITS-1:0] disp_s;
    logic [NW-1:0]       nd_s;
    logic                load_s;
    logic                step_s;
    logic                last_s;
    logic                in_ready_r;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_r[4*i +: 4]),
            .q (adj_s[4*i +: 4])
        );
    end

    assign shifted_s = (adj_s << 1) | {{(4*DIGITS-1){1'b0}}, bin_r[W-1]};
    assign in_ready  = in_ready_r;

    // significant digit count of the value produced by the current iteration
    always_comb begin
        nd_s = NW'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (shifted_s[4*i +: 4] != 4'd0) begin
                nd_s = NW'(i + 1);
            end else begin
                nd_s = nd_s;
            end
        end
    end

    // display formatting of the finished value
    always_comb begin
        disp_s = shifted_s;
`ifdef FIB_BCD_LZB_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (NW'(i) >= nd_s) begin
                disp_s[4*i +: 4] = BCD_BLANK;
            end else begin
                disp_s[4*i +: 4] = shifted_s[4*i +: 4];
            end
        end
`endif
    end

    // next-state and datapath strobes
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                step_s = 1'b1;
                if (cnt_r == CW'(1)) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state register and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
        end
    end

    // shift register, BCD accumulator and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
        end else if (load_s) begin
            bin_r <= in_data;
            bcd_r <= '0;
            cnt_r <= CW'(W);
        end else if (step_s) begin
            bin_r <= bin_r << 1;
            bcd_r <= shifted_s;
            cnt_r <= cnt_r - CW'(1);
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
        end
    end

    // result registers; out_bcd keeps its value after the output handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_bcd     <= '0;
            out_ndigits <= '0;
        end else if (last_s) begin
            out_valid   <= 1'b1;
            out_bcd     <= disp_s;
            out_ndigits <= nd_s;
        end else if (state_r == DONE && out_ready) begin
            out_valid   <= 1'b0;
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv against a decimal arithmetic reference model.
module tb_fib_bcd_conv;

    localparam int W = 32;
    localparam int DIGITS = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [4*DIGITS-1:0] out_bcd;
    logic [3:0]        out_ndigits;

    int tests = 0;
    int fails = 0;

    fib_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_ndigits (out_ndigits)
    );

    always #5 clk = ~clk;

    function automatic int model_nd(input logic [31:0] v);
        longint unsigned x = v;
        int n = 0;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [39:0] model_bcd(input logic [31:0] v);
        longint unsigned x = v;
        logic [39:0] r = '0;
        int nd = model_nd(v);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
`ifdef FIB_BCD_LZB_EN
            if (i >= nd) r[4*i +: 4] = 4'hF;
`endif
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 200);
    endtask

    task automatic check_result(input string name, input logic [31:0] v);
        tests++;
        if (out_bcd !== model_bcd(v)) begin
            fails++;
            $display("FAIL %s bcd: got %h expected %h", name, out_bcd, model_bcd(v));
        end
        tests++;
        if (out_ndigits !== 4'(model_nd(v))) begin
            fails++;
            $display("FAIL %s ndigits: got %0d expected %0d", name, out_ndigits, model_nd(v));
        end
    endtask

    // accept v, check latency, result and single-cycle out_valid (out_ready=1)
    task automatic convert(input string name, input logic [31:0] v);
        int n;
        in_data  = v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(n);
        tests++;
        if (n !== W) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, n, W);
        end
        check_result(name, v);
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s pulse: got valid=%b ready=%b expected valid=0 ready=1", name, out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset ctl: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        tests++;
        if (out_bcd !== 40'h0 || out_ndigits !== 4'd0) begin
            fails++;
            $display("FAIL reset data: got %h/%0d expected 0/0", out_bcd, out_ndigits);
        end
    endtask

    task automatic test_directed();
        convert("dir55", 32'd55);
        convert("dir0", 32'd0);
        convert("dirmax", 32'hFFFF_FFFF);
        convert("dir1e9", 32'd1000000000);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [31:0] v;
            v = $urandom();
            if (k[0]) v = v >> $urandom_range(31, 0);
            convert("random", v);
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_data = 32'd89;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_data = 32'd144;
        wait_result(n);
        tests++;
        if (n !== W) begin
            fails++;
            $display("FAIL bp latency: got %0d expected %0d", n, W);
        end
        for (int c = 0; c < 5; c++) begin
            check_result("bp hold", 32'd89);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp ctl: got valid=%b ready=%b expected 1/0", out_valid, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp accept: got ready=%b expected 0", in_ready);
        end
        wait_result(n);
        tests++;
        if (n !== W) begin
            fails++;
            $display("FAIL bp2 latency: got %0d expected %0d", n, W);
        end
        check_result("bp 144", 32'd144);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        in_data = 32'd233;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 40'h0) begin
            fails++;
            $display("FAIL midrst: got valid=%b ready=%b bcd=%h expected 0/1/0", out_valid, in_ready, out_bcd);
        end
        tick();
        rst = 1'b0;
        tick();
        convert("postrst 377", 32'd377);
    endtask

    task automatic test_back_to_back();
        logic [31:0] fibs[$];
        logic [31:0] sb[$];
        logic [31:0] a = 32'd1;
        logic [31:0] b = 32'd1;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        logic [31:0] exp_v;
        for (int k = 3; k <= 12; k++) begin
            fibs.push_back(a + b);
            a = b;
            b = fibs[$];
        end
        while (got < fibs.size() && cyc < 5000) begin
            in_valid  = (idx < fibs.size());
            in_data   = (idx < fibs.size()) ? fibs[idx] : 32'd0;
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b2b dup: got %h expected none", out_bcd);
                end else begin
                    exp_v = sb.pop_front();
                    check_result("b2b", exp_v);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(fibs[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (got !== fibs.size() || sb.size() !== 0) begin
            fails++;
            $display("FAIL b2b count: got %0d results expected %0d", got, fibs.size());
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        tick();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fib_bcd_conv.md
Name: fib_bcd_conv

Overview:
- Downstream consumer of the Fibonacci generator's W-bit result.
- Converts the unsigned binary value into packed BCD digits for a decimal display or readout.
- Iterative shift-and-add-3 (double dabble): one bit per clock.
- Valid/ready handshake on both sides, so it can sit between the generator and a display or log sink.

Parameters:
- W, 32, width of binary input.
- DIGITS, 10, number of BCD output digits; must satisfy DIGITS >= ceil(W*log10(2)). Elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a value on in_data.
- in_ready  output  1  block can accept; equals (state==IDLE).
- in_data  input  W  unsigned binary value to convert.
- out_valid  output  1  out_bcd/out_ndigits hold a finished result.
- out_ready  input  1  downstream accepts the result.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- out_ndigits  output  clog2(DIGITS+1)  count of significant digits; value 0 reports 1.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, out_valid=0, out_bcd=0, out_ndigits=0, in_ready=1.
  - Internal shift register and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_valid && in_ready at an edge captures in_data into the shift register.
  - Clears the BCD accumulator, loads counter=W, goes to SHIFT.
- SHIFT, one iteration per clock:
  - Every BCD digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1; counter decrements.
  - When counter reaches 1 at an edge, the final iteration completes and state goes to DONE.
- Latency: out_valid rises exactly W clocks after the accepting edge (32 for default).
- DONE:
  - out_valid=1; out_bcd/out_ndigits registered and stable.
  - Outputs do not change while out_ready=0.
  - out_valid && out_ready at an edge: state goes to IDLE, out_valid=0. out_bcd retains its last value.
- in_ready=0 in SHIFT and DONE. in_valid there is ignored; data is not captured or queued.
- No same-cycle turnaround: a new input can be accepted at the earliest one cycle after the output handshake.
- out_ndigits = index of most-significant nonzero digit + 1; 1 when the value is 0.
- Arithmetic: per-digit add is 4-bit, no carry between digits (add-3 never overflows for digit <= 9). The binary part is unsigned with no sign handling.
- Reset mid-SHIFT or mid-DONE aborts immediately to reset values; the partial result is discarded.
- in_data all-ones converts correctly (4294967295 for W=32).

Optional Feature:
- Macro FIB_BCD_LZB_EN: leading-zero blanking.
- Defined: digits above position out_ndigits-1 read 4'hF (blank code) in out_bcd. Value 0 shows digit0=0, all others F.
- Undefined: out_bcd is raw BCD with leading zeros.
- out_ndigits behaves identically either way.

Decomposition:
- Shared package fib_pkg holds:
  - FIB_W default (32).
  - BCD_BLANK = 4'hF.
  - State enum {IDLE, SHIFT, DONE}.
  - Digit-count helper function for DIGITS from W.
- One combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out, +3 when >=5), instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_data=55 with in_valid pulse, out_ready=1: out_valid exactly 32 clocks after accept; out_bcd=0x0000000055; out_ndigits=2. Single-cycle out_valid.
- in_data=0: out_bcd=0, out_ndigits=1. in_data=32'hFFFFFFFF: out_bcd=0x4294967295, out_ndigits=10.
- Backpressure: convert 89, hold out_ready=0 for 5 cycles with in_valid=1 and in_data=144. Outputs stay 0x89, in_ready=0, 144 is not captured. Release out_ready: in_ready=1 next cycle and 144 is accepted.
- Reset asserted 10 clocks into converting 233: out_valid=0, in_ready=1 asynchronously. After release, converting 377 yields 0x377 with normal 32-clock latency.
- Back-to-back stream of fib(3..12) (2,3,5,...,144) with random out_ready stalls: every result matches the scoreboard; no drops or duplicates.
- With FIB_BCD_LZB_EN: 55 gives out_bcd=0xFFFFFFFF55, and 0 gives 0xFFFFFFFFF0. Without the macro, same inputs give 0x0000000055 and 0.
